// File: rtl/chain_code_decoder.sv
// Freeman chain-code decoder: traces a path on a 64x64 bitmap, checks closure and area, then streams the bitmap serially.
// Latency 1 + primeter + 4096 + 1 cycles per job; no backpressure, one code is consumed every TRACE cycle.
module chain_code_decoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  code,
   input  logic [7:0]  primeter,
   input  logic [11:0] area,
   input  logic [6:0]  start_row,
   input  logic [6:0]  start_col,
   output logic [63:0] debug1,
   output logic [63:0] debug2,
   output logic [63:0] debug3,
   output logic [63:0] debug4,
   output logic [63:0] debug5,
   output logic [63:0] debug6,
   output logic        pixel,
   output logic        done,
   output logic        error
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_TRACE  = 2'b01,
      S_OUTPUT = 2'b10,
      S_DONE   = 2'b11
   } state_t;

   state_t             state_q, state_d;
   logic [4095:0]      bitmap_q, bitmap_d;
   logic [6:0]         row_q, row_d, col_q, col_d;
   logic [6:0]         srow_q, srow_d, scol_q, scol_d;
   logic [7:0]         step_q, step_d, prim_q, prim_d;
   logic [11:0]        area_q, area_d, idx_q, idx_d;
   logic signed [23:0] acc_q, acc_d;
   logic               err_q, err_d;
   logic               pixel_q, pixel_d;
   logic               done_q, done_d;
   logic               error_q, error_d;

   logic signed [8:0]  dr, dc, nr, nc;
   logic               in_grid;
   logic signed [23:0] term;
   logic [23:0]        acc_abs;

   always_comb begin
      dr = '0;
      dc = '0;
      case (code)
         3'd0:    dc = 9'sd1;
         3'd1:    begin dr = -9'sd1; dc = 9'sd1;  end
         3'd2:    dr = -9'sd1;
         3'd3:    begin dr = -9'sd1; dc = -9'sd1; end
         3'd4:    dc = -9'sd1;
         3'd5:    begin dr = 9'sd1;  dc = -9'sd1; end
         3'd6:    dr = 9'sd1;
         default: begin dr = 9'sd1;  dc = 9'sd1;  end
      endcase
      nr = $signed({2'b00, row_q}) + dr;
      nc = $signed({2'b00, col_q}) + dc;
      // Inside 0..63 exactly when the sign bit and bits 7:6 are all clear.
      in_grid = (nr[8:6] == 3'b000) && (nc[8:6] == 3'b000);
      term = $signed({17'd0, col_q}) * $signed({{15{nr[8]}}, nr})
           - $signed({{15{nc[8]}}, nc}) * $signed({17'd0, row_q});
      acc_abs = acc_q[23] ? -acc_q : acc_q;
   end

   always_comb begin
      state_d  = state_q;
      bitmap_d = bitmap_q;
      row_d    = row_q;
      col_d    = col_q;
      srow_d   = srow_q;
      scol_d   = scol_q;
      step_d   = step_q;
      prim_d   = prim_q;
      area_d   = area_q;
      idx_d    = idx_q;
      acc_d    = acc_q;
      err_d    = err_q;
      pixel_d  = 1'b0;
      done_d   = 1'b0;
      error_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               prim_d   = primeter;
               area_d   = area;
               srow_d   = start_row;
               scol_d   = start_col;
               row_d    = start_row;
               col_d    = start_col;
               step_d   = '0;
               acc_d    = '0;
               idx_d    = '0;
               bitmap_d = '0;
               err_d    = 1'b0;
               if (start_row > 7'd63 || start_col > 7'd63) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  error_d = 1'b1;
               end else begin
                  bitmap_d[{start_row[5:0], start_col[5:0]}] = 1'b1;
                  state_d = (primeter == 8'd0) ? S_OUTPUT : S_TRACE;
               end
            end
         end
         S_TRACE: begin
            if (!in_grid) begin
               err_d   = 1'b1;
               state_d = S_DONE;
               done_d  = 1'b1;
               error_d = 1'b1;
            end else begin
               row_d  = nr[6:0];
               col_d  = nc[6:0];
               bitmap_d[{nr[5:0], nc[5:0]}] = 1'b1;
               step_d = step_q + 8'd1;
               acc_d  = acc_q + term;
               if (step_d == prim_q) begin
                  state_d = S_OUTPUT;
               end
            end
         end
         S_OUTPUT: begin
            pixel_d = bitmap_q[idx_q];
            if (idx_q == 12'd4095) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               error_d = err_q || (row_q != srow_q) || (col_q != scol_q)
                       || (acc_abs != {11'd0, area_q, 1'b0});
            end else begin
               idx_d = idx_q + 12'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         bitmap_q <= '0;
         row_q    <= '0;
         col_q    <= '0;
         srow_q   <= '0;
         scol_q   <= '0;
         step_q   <= '0;
         prim_q   <= '0;
         area_q   <= '0;
         idx_q    <= '0;
         acc_q    <= '0;
         err_q    <= 1'b0;
         pixel_q  <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitmap_q <= bitmap_d;
         row_q    <= row_d;
         col_q    <= col_d;
         srow_q   <= srow_d;
         scol_q   <= scol_d;
         step_q   <= step_d;
         prim_q   <= prim_d;
         area_q   <= area_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         err_q    <= err_d;
         pixel_q  <= pixel_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   assign pixel  = pixel_q;
   assign done   = done_q;
   assign error  = error_q;
   assign debug1 = {57'd0, row_q};
   assign debug2 = {57'd0, col_q};
   assign debug3 = {56'd0, step_q};
   assign debug4 = {{40{acc_q[23]}}, acc_q};
   assign debug5 = {52'd0, idx_q};
   assign debug6 = {62'd0, state_q};

endmodule

// File: tb/tb_chain_code_decoder.sv
// Directed bench for chain_code_decoder: table of jobs with hand-computed results,
// plus start-held repeat and mid-stream reset sequences.
module tb_chain_code_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  code;
   logic [7:0]  primeter;
   logic [11:0] area;
   logic [6:0]  start_row;
   logic [6:0]  start_col;
   logic [63:0] debug1, debug2, debug3, debug4, debug5, debug6;
   logic        pixel, done, error;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   chain_code_decoder dut (
      .clk(clk), .reset(reset), .start(start), .code(code),
      .primeter(primeter), .area(area), .start_row(start_row), .start_col(start_col),
      .debug1(debug1), .debug2(debug2), .debug3(debug3), .debug4(debug4),
      .debug5(debug5), .debug6(debug6), .pixel(pixel), .done(done), .error(error)
   );

   typedef struct packed {
      logic [6:0]        srow;
      logic [6:0]        scol;
      logic [7:0]        prim;
      logic [11:0]       area;
      logic [7:0][2:0]   codes;
      logic              exp_err;
      logic [63:0]       exp_acc;
      int                exp_done;
      logic [6:0]        exp_row;
      logic [6:0]        exp_col;
      int                exp_n;
      logic [3:0][11:0]  exp_px;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Runs one job from IDLE; cycle 0 is the cycle after the edge that samples start.
   task automatic run_job(input int ti, input bit hold);
      vec_t        v;
      logic [4095:0] bm;
      int          c, done_cyc, stray, nset;
      logic        got_err;
      logic [63:0] got_acc, got_row, got_col;
      v = vecs[ti];
      bm = '0;
      stray = 0;
      done_cyc = -1;
      got_err = 1'b0;
      got_acc = '0;
      got_row = '0;
      got_col = '0;
      @(negedge clk);
      start = 1'b1;
      start_row = v.srow;
      start_col = v.scol;
      primeter = v.prim;
      area = v.area;
      code = 3'd0;
      c = 0;
      while (c < int'(v.prim) + 4200 && done_cyc < 0) begin
         @(negedge clk);
         if (!hold) begin
            start = 1'b0;
            start_row = 7'd5;
            start_col = 7'd40;
            primeter = 8'd200;
            area = 12'd77;
         end
         code = (c < 8 && c < int'(v.prim)) ? v.codes[c] : 3'd0;
         if (c >= int'(v.prim) + 1 && c <= int'(v.prim) + 4096)
            bm[c - int'(v.prim) - 1] = pixel;
         else if (pixel !== 1'b0)
            stray++;
         if (done === 1'b1) begin
            done_cyc = c;
            got_err = error;
            got_acc = debug4;
            got_row = debug1;
            got_col = debug2;
         end
         c++;
      end
      if (done_cyc < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL v%0d_timeout: no done within %0d cycles", ti, c);
      end else begin
         nset = 0;
         for (int i = 0; i < 4096; i++) if (bm[i]) nset++;
         check($sformatf("v%0d_done_cycle", ti), 64'(done_cyc), 64'(v.exp_done));
         check($sformatf("v%0d_error", ti), 64'(got_err), 64'(v.exp_err));
         check($sformatf("v%0d_acc", ti), got_acc, v.exp_acc);
         check($sformatf("v%0d_row", ti), got_row, 64'(v.exp_row));
         check($sformatf("v%0d_col", ti), got_col, 64'(v.exp_col));
         check($sformatf("v%0d_pixel_count", ti), 64'(nset), 64'(v.exp_n));
         check($sformatf("v%0d_stray_pixels", ti), 64'(stray), 64'd0);
         for (int i = 0; i < v.exp_n; i++)
            check($sformatf("v%0d_pixel_%0d", ti, v.exp_px[i]), 64'(bm[v.exp_px[i]]), 64'd1);
      end
   endtask

   initial begin
      int dones;
      vecs[0] = '{srow:7'd10, scol:7'd10, prim:8'd0, area:12'd0, codes:24'o0,
                  exp_err:1'b0, exp_acc:64'd0, exp_done:4096, exp_row:7'd10, exp_col:7'd10,
                  exp_n:1, exp_px:{12'd0, 12'd0, 12'd0, 12'd650}};
      vecs[1] = '{srow:7'd10, scol:7'd10, prim:8'd4, area:12'd1, codes:24'o2460,
                  exp_err:1'b0, exp_acc:64'd2, exp_done:4100, exp_row:7'd10, exp_col:7'd10,
                  exp_n:4, exp_px:{12'd714, 12'd715, 12'd651, 12'd650}};
      vecs[2] = '{srow:7'd10, scol:7'd10, prim:8'd4, area:12'd2, codes:24'o2460,
                  exp_err:1'b1, exp_acc:64'd2, exp_done:4100, exp_row:7'd10, exp_col:7'd10,
                  exp_n:4, exp_px:{12'd714, 12'd715, 12'd651, 12'd650}};
      vecs[3] = '{srow:7'd10, scol:7'd10, prim:8'd2, area:12'd0, codes:24'o00,
                  exp_err:1'b1, exp_acc:64'hFFFF_FFFF_FFFF_FFEC, exp_done:4098, exp_row:7'd10,
                  exp_col:7'd12, exp_n:3, exp_px:{12'd0, 12'd652, 12'd651, 12'd650}};
      vecs[4] = '{srow:7'd64, scol:7'd0, prim:8'd3, area:12'd0, codes:24'o0,
                  exp_err:1'b1, exp_acc:64'd0, exp_done:0, exp_row:7'd64, exp_col:7'd0,
                  exp_n:0, exp_px:'0};
      vecs[5] = '{srow:7'd0, scol:7'd0, prim:8'd1, area:12'd0, codes:24'o2,
                  exp_err:1'b1, exp_acc:64'd0, exp_done:1, exp_row:7'd0, exp_col:7'd0,
                  exp_n:0, exp_px:'0};
      vecs[6] = '{srow:7'd20, scol:7'd20, prim:8'd4, area:12'd2, codes:24'o3571,
                  exp_err:1'b0, exp_acc:64'd4, exp_done:4100, exp_row:7'd20, exp_col:7'd20,
                  exp_n:4, exp_px:{12'd1300, 12'd1365, 12'd1302, 12'd1237}};
      vecs[7] = '{srow:7'd10, scol:7'd10, prim:8'd4, area:12'd1, codes:24'o4206,
                  exp_err:1'b0, exp_acc:64'hFFFF_FFFF_FFFF_FFFE, exp_done:4100, exp_row:7'd10,
                  exp_col:7'd10, exp_n:4, exp_px:{12'd651, 12'd715, 12'd714, 12'd650}};
      vecs[8] = '{srow:7'd63, scol:7'd62, prim:8'd2, area:12'd0, codes:24'o00,
                  exp_err:1'b1, exp_acc:64'hFFFF_FFFF_FFFF_FFC1, exp_done:2, exp_row:7'd63,
                  exp_col:7'd63, exp_n:0, exp_px:'0};

      reset = 1'b1;
      start = 1'b0;
      code = 3'd0;
      primeter = 8'd0;
      area = 12'd0;
      start_row = 7'd0;
      start_col = 7'd0;
      @(negedge clk);
      reset = 1'b0;
      check("rst_state", debug6, 64'd0);
      check("rst_row", debug1, 64'd0);
      check("rst_col", debug2, 64'd0);
      check("rst_step", debug3, 64'd0);
      check("rst_acc", debug4, 64'd0);
      check("rst_idx", debug5, 64'd0);
      check("rst_outs", {61'd0, pixel, done, error}, 64'd0);

      for (int t = 0; t < 9; t++) run_job(t, 1'b0);

      // start held high: job 0 completes, then a fresh job starts from IDLE.
      run_job(0, 1'b1);
      @(negedge clk);
      check("rep_idle_state", debug6, 64'd0);
      check("rep_idle_done", 64'(done), 64'd0);
      @(negedge clk);
      check("rep_output_state", debug6, 64'd2);
      check("rep_output_idx", debug5, 64'd0);
      start = 1'b0;
      repeat (1000) @(negedge clk);
      check("mid_idx", debug5, 64'd1000);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_state", debug6, 64'd0);
      check("abort_pixel", 64'(pixel), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_idx", debug5, 64'd0);
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1 || debug6 !== 64'd0) dones++;
      end
      check("abort_quiet", 64'(dones), 64'd0);

      run_job(1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
